div_cfg_select: RTL and testbench

Parametrised source selector for the clock divider's ratio. It takes N receive channels, each with a data bus and a done strobe (UART, I2C, SPI and future ones). It validates values from the selected channel, stages them, and commits them to the divider only when the divider acknowledges a period boundary, so the ratio never changes mid-period. It sits between the interface receivers and clk_div, and replaces the fixed three-source selector.

---
 rtl/div_cfg_pkg.sv | 14 +
 rtl/div_cfg_select.sv | 134 +++++++++++++
 tb/tb_div_cfg_select.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/div_cfg_pkg.sv
// Shared types and defaults for the divider-ratio source selector.
// The selector and the clk_div top both import this package.
package div_cfg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } div_state_e;

  localparam int DIV_DW_DEF      = 8;
  localparam int DIV_DEFAULT_DEF = 1;
  localparam int REJ_CNT_W       = 8;

endpackage

// File: rtl/div_cfg_select.sv
// Selects one of CH_NUM receive channels and range-checks its value. A good value is
// staged, then committed to the divider only on a period-boundary ack from the divider.
//
// Handshake: a staged value is offered while div_upd_o is high (the request). div_ack_i
// is a one-cycle acknowledge that is honoured only while the request is high. The staged
// value moves to div_data_o on the clock edge that ends the ack cycle.
module div_cfg_select
  import div_cfg_pkg::*;
#(
  parameter int CH_NUM      = 3,
  parameter int DW          = DIV_DW_DEF,
  parameter int DEFAULT_DIV = DIV_DEFAULT_DEF,
  parameter int MIN_DIV     = 1,
  parameter int MAX_DIV     = 2**DW - 1,
  parameter int SEL_W       = $clog2(CH_NUM + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic [SEL_W-1:0]       sel_i,
  input  logic [CH_NUM*DW-1:0]   ch_data_i,
  input  logic [CH_NUM-1:0]      ch_done_i,
  input  logic                   div_ack_i,
  output logic [DW-1:0]          div_data_o,
  output logic                   div_upd_o,
  output logic                   rej_o,
  output logic [REJ_CNT_W-1:0]   rej_cnt_o,
  output div_state_e             dbg_state_o
);

  typedef struct packed {
    logic          hit;
    logic          ok;
    logic [DW-1:0] val;
  } pick_t;

  // Channel mux plus unsigned range check. A select value of CH_NUM or above never hits.
  function automatic pick_t pick(input logic [SEL_W-1:0]     sel,
                                 input logic [CH_NUM*DW-1:0] data,
                                 input logic [CH_NUM-1:0]    done);
    pick_t       p;
    logic [31:0] v32;
    p = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (sel == SEL_W'(k)) begin
        p.hit = done[k];
        p.val = data[k*DW +: DW];
      end
    end
    v32  = 32'(p.val);
    p.ok = (v32 >= 32'(MIN_DIV)) && (v32 <= 32'(MAX_DIV));
    return p;
  endfunction

  div_state_e           state_q, state_d;
  logic [DW-1:0]        stage_q, stage_d;
  logic [DW-1:0]        div_q, div_d;
  logic                 rej_q, rej_d;
  logic [REJ_CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;

  pick_t pk;
  logic  acc_ok;
  logic  acc_bad;
  logic  sel_chg;

  always_comb begin
    pk      = pick(sel_i, ch_data_i, ch_done_i);
    acc_ok  = pk.hit & pk.ok;
    acc_bad = pk.hit & ~pk.ok;
    sel_chg = (sel_i != sel_q);

    state_d = state_q;
    stage_d = stage_q;
    div_d   = div_q;
    sel_d   = sel_i;
    rej_d   = acc_bad;
    cnt_d   = (acc_bad && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    case (state_q)
      IDLE: begin
        if (acc_ok) begin
          stage_d = pk.val;
          state_d = PEND;
        end
      end
      PEND: begin
        // A select change aborts the pending value, and it also suppresses a same-cycle ack.
        if (sel_chg) begin
          if (acc_ok) begin
            stage_d = pk.val;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (div_ack_i) begin
            div_d = stage_q;
            if (!acc_ok) begin
              state_d = IDLE;
            end
          end
          if (acc_ok) begin
            stage_d = pk.val;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= DW'(DEFAULT_DIV);
      div_q   <= DW'(DEFAULT_DIV);
      rej_q   <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      div_q   <= div_d;
      rej_q   <= rej_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign div_data_o  = div_q;
  assign div_upd_o   = (state_q == PEND);
  assign rej_o       = rej_q;
  assign rej_cnt_o   = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_cfg_select.sv
// Directed bench for div_cfg_select with CH_NUM=3, DW=8 and MIN=1, MAX=255.
// Inputs change on the falling edge, and outputs are compared on the following falling edge.
module tb_div_cfg_select;
  import div_cfg_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [1:0]  sel_i;
  logic [23:0] ch_data_i;
  logic [2:0]  ch_done_i;
  logic        div_ack_i;
  logic [7:0]  div_data_o;
  logic        div_upd_o;
  logic        rej_o;
  logic [7:0]  rej_cnt_o;
  div_state_e  dbg_state_o;

  int total  = 0;
  int passed = 0;

  div_cfg_select #(.CH_NUM(3), .DW(8), .DEFAULT_DIV(1), .MIN_DIV(1), .MAX_DIV(255)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .sel_i(sel_i), .ch_data_i(ch_data_i),
    .ch_done_i(ch_done_i), .div_ack_i(div_ack_i), .div_data_o(div_data_o),
    .div_upd_o(div_upd_o), .rej_o(rej_o), .rej_cnt_o(rej_cnt_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] d0, d1, d2;
    logic [2:0] done;
    logic       ack;
    logic [7:0] e_data;
    logic       e_upd;
    logic       e_rej;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic u,
                         input logic r, input logic [7:0] c);
    chk({tag, " data"}, 32'(div_data_o), 32'(d));
    chk({tag, " upd"},  32'(div_upd_o),  32'(u));
    chk({tag, " rej"},  32'(rej_o),      32'(r));
    chk({tag, " cnt"},  32'(rej_cnt_o),  32'(c));
    chk({tag, " state"}, 32'(dbg_state_o), u ? 32'(PEND) : 32'(IDLE));
  endtask

  task automatic drive(input logic [1:0] sel, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [2:0] done, input logic ack);
    sel_i     = sel;
    ch_data_i = {d2, d1, d0};
    ch_done_i = done;
    div_ack_i = ack;
  endtask

  initial begin
    // sel d0 d1 d2 done ack | data upd rej cnt  (expected after the edge)
    tbl.push_back('{2'd2, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h01, 1'b0, 1'b0, 8'd0}); // r0
    tbl.push_back('{2'd2, 8'h00, 8'h00, 8'h10, 3'b100, 1'b0, 8'h01, 1'b1, 1'b0, 8'd0}); // r1 accept 0x10
    tbl.push_back('{2'd2, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h01, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{2'd2, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h01, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{2'd2, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h01, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{2'd2, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 8'h10, 1'b0, 1'b0, 8'd0}); // r5 ack commits
    tbl.push_back('{2'd2, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 8'h10, 1'b0, 1'b0, 8'd0}); // ack in IDLE ignored
    tbl.push_back('{2'd0, 8'h00, 8'h00, 8'h00, 3'b001, 1'b0, 8'h10, 1'b0, 1'b1, 8'd1}); // r7 reject 0x00
    tbl.push_back('{2'd0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h10, 1'b0, 1'b0, 8'd1}); // rej is one pulse
    tbl.push_back('{2'd0, 8'h00, 8'h55, 8'h66, 3'b110, 1'b0, 8'h10, 1'b0, 1'b0, 8'd1}); // other channels ignored
    tbl.push_back('{2'd0, 8'h20, 8'h00, 8'h00, 3'b001, 1'b0, 8'h10, 1'b1, 1'b0, 8'd1}); // r10 stage 0x20
    tbl.push_back('{2'd0, 8'h30, 8'h00, 8'h00, 3'b001, 1'b0, 8'h10, 1'b1, 1'b0, 8'd1}); // latest wins
    tbl.push_back('{2'd0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 8'h30, 1'b0, 1'b0, 8'd1}); // r12 commit 0x30
    tbl.push_back('{2'd0, 8'h25, 8'h00, 8'h00, 3'b001, 1'b0, 8'h30, 1'b1, 1'b0, 8'd1}); // stage 0x25
    tbl.push_back('{2'd0, 8'h40, 8'h00, 8'h00, 3'b001, 1'b1, 8'h25, 1'b1, 1'b0, 8'd1}); // r14 ack+accept
    tbl.push_back('{2'd0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 8'h40, 1'b0, 1'b0, 8'd1}); // staged 0x40 commits
    tbl.push_back('{2'd0, 8'h44, 8'h00, 8'h00, 3'b001, 1'b0, 8'h40, 1'b1, 1'b0, 8'd1}); // r16 stage 0x44
    tbl.push_back('{2'd0, 8'h00, 8'h00, 8'h00, 3'b001, 1'b0, 8'h40, 1'b1, 1'b1, 8'd2}); // reject in PEND
    tbl.push_back('{2'd0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 8'h44, 1'b0, 1'b0, 8'd2}); // staging intact
    tbl.push_back('{2'd1, 8'h00, 8'h50, 8'h00, 3'b010, 1'b0, 8'h44, 1'b1, 1'b0, 8'd2}); // r19 stage on ch1
    tbl.push_back('{2'd0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h44, 1'b0, 1'b0, 8'd2}); // sel 1->0 abort
    tbl.push_back('{2'd0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 8'h44, 1'b0, 1'b0, 8'd2}); // nothing to commit
    tbl.push_back('{2'd0, 8'h60, 8'h00, 8'h00, 3'b001, 1'b0, 8'h44, 1'b1, 1'b0, 8'd2}); // r22 stage 0x60
    tbl.push_back('{2'd1, 8'h00, 8'h70, 8'h00, 3'b010, 1'b0, 8'h44, 1'b1, 1'b0, 8'd2}); // abort+accept 0x70
    tbl.push_back('{2'd1, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 8'h70, 1'b0, 1'b0, 8'd2}); // 0x70 commits
    tbl.push_back('{2'd1, 8'h00, 8'h80, 8'h00, 3'b010, 1'b0, 8'h70, 1'b1, 1'b0, 8'd2}); // r25 stage 0x80
    tbl.push_back('{2'd2, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 8'h70, 1'b0, 1'b0, 8'd2}); // abort beats ack
    tbl.push_back('{2'd3, 8'h00, 8'h00, 8'h00, 3'b111, 1'b0, 8'h70, 1'b0, 1'b0, 8'd2}); // no source, no reject
    tbl.push_back('{2'd3, 8'h99, 8'h99, 8'h99, 3'b111, 1'b1, 8'h70, 1'b0, 1'b0, 8'd2}); // no source, no accept
    tbl.push_back('{2'd0, 8'h11, 8'h00, 8'h00, 3'b001, 1'b0, 8'h70, 1'b1, 1'b0, 8'd2}); // r29 stage 0x11
    tbl.push_back('{2'd3, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h70, 1'b0, 1'b0, 8'd2}); // to no-source aborts

    rst_n = 1'b0;
    drive(2'd0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
    repeat (2) @(negedge clk_i);
    chk_all("in_reset", 8'h01, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      chk_all($sformatf("idle%0d", c), 8'h01, 1'b0, 1'b0, 8'd0);
    end

    foreach (tbl[i]) begin
      drive(tbl[i].sel, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].done, tbl[i].ack);
      @(negedge clk_i);
      chk_all($sformatf("row%0d", i), tbl[i].e_data, tbl[i].e_upd, tbl[i].e_rej, tbl[i].e_cnt);
    end

    // Rejection counter saturation: the count starts at 2 here.
    drive(2'd0, 8'h00, 8'h00, 8'h00, 3'b001, 1'b0);
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk_i);
      if (n == 252) chk("sat_n252", 32'(rej_cnt_o), 32'd254);
      if (n == 253) chk("sat_n253", 32'(rej_cnt_o), 32'd255);
      if (n == 300) begin
        chk("sat_n300", 32'(rej_cnt_o), 32'd255);
        chk("sat_rej",  32'(rej_o), 32'd1);
        chk("sat_data", 32'(div_data_o), 32'h70);
        chk("sat_upd",  32'(div_upd_o), 32'd0);
      end
    end

    // Asynchronous reset while a value is pending.
    drive(2'd0, 8'h33, 8'h00, 8'h00, 3'b001, 1'b0);
    @(negedge clk_i);
    chk_all("pre_rst", 8'h70, 1'b1, 1'b0, 8'd255);
    drive(2'd0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 8'h01, 1'b0, 1'b0, 8'd0);
    #1 rst_n = 1'b1;
    div_ack_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk_all($sformatf("post_rst%0d", c), 8'h01, 1'b0, 1'b0, 8'd0);
    end
    div_ack_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
